// File: rtl/dcache_pkg.sv
// Shared types, default geometry and helpers for the set-associative data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FETCH  = 2'd2,
    UPDATE = 2'd3
  } state_e;

  localparam int DEF_WAYS   = 2;
  localparam int DEF_SETS   = 8;
  localparam int DEF_WPB    = 4;
  localparam int DEF_ADDR_W = 32;

  localparam int BYTE_W = 2;
  localparam int WORD_W = $clog2(DEF_WPB);
  localparam int IDX_W  = $clog2(DEF_SETS);
  localparam int TAG_W  = DEF_ADDR_W - BYTE_W - WORD_W - IDX_W;

  // A 1-way cache still needs a 1-bit way/age field to keep vectors legal.
  function automatic int way_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_lru.sv
// True-LRU age tracking per set; age 0 is most recent, age WAYS-1 is the victim.
module dcache_lru
  import dcache_pkg::*;
#(
  parameter int WAYS = DEF_WAYS,
  parameter int SETS = DEF_SETS,
  localparam int WAY_W = way_bits(WAYS),
  localparam int SIDX_W = $clog2(SETS)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [SIDX_W-1:0] set_idx_i,
  input  logic [WAY_W-1:0]  access_way_i,
  input  logic              access_i,
  output logic [WAY_W-1:0]  victim_way_o
);

  logic [WAY_W-1:0] age_q [SETS][WAYS];

  // NOTE: the age array is small enough to reset in place; large data memories are not reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else if (access_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == access_way_i) begin
          age_q[set_idx_i][w] <= '0;
        end else if (age_q[set_idx_i][w] < age_q[set_idx_i][access_way_i]) begin
          age_q[set_idx_i][w] <= age_q[set_idx_i][w] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    victim_way_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[set_idx_i][w] == WAY_W'(WAYS - 1)) victim_way_o = WAY_W'(w);
    end
  end

endmodule

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU
// replacement and byte-enabled stores; misses stall the CPU via BUSYWAIT.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int WAYS            = DEF_WAYS,
  parameter int SETS            = DEF_SETS,
  parameter int WORDS_PER_BLOCK = DEF_WPB,
  parameter int ADDR_W          = DEF_ADDR_W,
  localparam int OFF_W = BYTE_W + $clog2(WORDS_PER_BLOCK),
  localparam int BLK_W = 32 * WORDS_PER_BLOCK
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [3:0]            BYTE_EN,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [31:0]           WRITEDATA,
  output logic [31:0]           READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_W-OFF_W-1:0] MEM_ADDRESS,
  output logic [BLK_W-1:0]      MEM_WRITEDATA,
  input  logic [BLK_W-1:0]      MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  localparam int WOFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int SIDX_W = $clog2(SETS);
  localparam int CTAG_W = ADDR_W - OFF_W - SIDX_W;
  localparam int WAY_W  = way_bits(WAYS);

  logic [WOFF_W-1:0] addr_word;
  logic [SIDX_W-1:0] addr_idx;
  logic [CTAG_W-1:0] addr_tag;

  assign addr_word = ADDRESS[BYTE_W +: WOFF_W];
  assign addr_idx  = ADDRESS[OFF_W +: SIDX_W];
  assign addr_tag  = ADDRESS[ADDR_W-1 -: CTAG_W];

  logic              valid_q [WAYS][SETS];
  logic              dirty_q [WAYS][SETS];
  logic [CTAG_W-1:0] tag_q   [WAYS][SETS];
  logic [BLK_W-1:0]  data_q  [WAYS][SETS];
  logic [BLK_W-1:0]  fill_q;

  state_e            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d;

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [31:0]       hit_word;
  logic [WAY_W-1:0]  lru_victim;
  logic [WAY_W-1:0]  victim_sel;
  logic              req;
  logic              store_hit;
  logic              fill_en;
  logic              fetch_done;
  logic              lru_access;
  logic [WAY_W-1:0]  lru_way;

  // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][addr_idx] && (tag_q[w][addr_idx] == addr_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_word = data_q[hit_way][addr_idx][32*addr_word +: 32];
  assign READDATA = hit ? hit_word : 32'h0;

  // An invalid way is always preferred over evicting the LRU line.
  always_comb begin
    victim_sel = lru_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][addr_idx]) victim_sel = WAY_W'(w);
    end
  end

  dcache_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .set_idx_i    (addr_idx),
    .access_way_i (lru_way),
    .access_i     (lru_access),
    .victim_way_o (lru_victim)
  );

  // Requests are ignored while reset is held so the stall drops immediately.
  assign req = (READ | WRITE) & RESET_N;

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    store_hit     = 1'b0;
    fill_en       = 1'b0;
    fetch_done    = 1'b0;
    lru_access    = 1'b0;
    lru_way       = hit_way;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            lru_access = 1'b1;
            store_hit  = WRITE;
          end else begin
            BUSYWAIT = 1'b1;
            victim_d = victim_sel;
            state_d  = (valid_q[victim_sel][addr_idx] && dirty_q[victim_sel][addr_idx])
                       ? WB : FETCH;
          end
        end
      end
      WB: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[victim_q][addr_idx], addr_idx};
        MEM_WRITEDATA = data_q[victim_q][addr_idx];
        if (!MEM_BUSYWAIT) state_d = FETCH;
      end
      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = ADDRESS[ADDR_W-1:OFF_W];
        if (!MEM_BUSYWAIT) begin
          fetch_done = 1'b1;
          state_d    = UPDATE;
        end
      end
      UPDATE: begin
        BUSYWAIT   = 1'b1;
        fill_en    = 1'b1;
        lru_access = 1'b1;
        lru_way    = victim_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      victim_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (store_hit && (BYTE_EN != 4'b0000)) dirty_q[hit_way][addr_idx] <= 1'b1;
      if (fill_en) begin
        valid_q[victim_q][addr_idx] <= 1'b1;
        dirty_q[victim_q][addr_idx] <= 1'b0;
      end
    end
  end

  // Tag and data contents are qualified by valid, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (store_hit) begin
      data_q[hit_way][addr_idx][32*addr_word +: 32] <= merge_bytes(hit_word, WRITEDATA, BYTE_EN);
    end
    if (fill_en) begin
      data_q[victim_q][addr_idx] <= fill_q;
      tag_q[victim_q][addr_idx]  <= addr_tag;
    end
    if (fetch_done) fill_q <= MEM_READDATA;
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc (2 ways, 8 sets, 4-word blocks) against a 5-cycle memory.
module tb_dcache_assoc;

  localparam int LAT   = 5;
  localparam int LIMIT = 200;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         READ, WRITE;
  logic [3:0]   BYTE_EN;
  logic [31:0]  ADDRESS, WRITEDATA, READDATA;
  logic         BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA, MEM_READDATA;

  int errors = 0;
  int checks = 0;

  logic [127:0] mem [64];
  int           cnt = 0;

  logic         saw_rd, saw_wr;
  logic [27:0]  rd_addr, wr_addr;
  logic [127:0] wr_data;
  int           cyc;

  always #5 CLK = ~CLK;

  dcache_assoc dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .READ          (READ),
    .WRITE         (WRITE),
    .BYTE_EN       (BYTE_EN),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  // Block memory: busy for LAT cycles of a request, ready on the following one.
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (cnt != LAT);
  assign MEM_READDATA = mem[MEM_ADDRESS[5:0]];

  always @(posedge CLK) begin
    if (!(MEM_READ | MEM_WRITE)) cnt <= 0;
    else if (cnt == LAT) begin
      cnt <= 0;
      if (MEM_WRITE) mem[MEM_ADDRESS[5:0]] <= MEM_WRITEDATA;
    end else cnt <= cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d; BYTE_EN = be;
    saw_rd = 1'b0; saw_wr = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    #1;
  endtask

  task automatic wait_ready();
    cyc = 0;
    while (BUSYWAIT && cyc < LIMIT) begin
      if (MEM_WRITE && !saw_wr) begin saw_wr = 1'b1; wr_addr = MEM_ADDRESS; wr_data = MEM_WRITEDATA; end
      if (MEM_READ && !saw_rd)  begin saw_rd = 1'b1; rd_addr = MEM_ADDRESS; end
      @(posedge CLK); #2;
      cyc++;
    end
    if (cyc >= LIMIT) check("stall_timeout", 128'(cyc), 128'(LIMIT - 1));
  endtask

  // Let the held request take its edge (promotion/store) and then release it.
  task automatic finish_req();
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    for (int b = 0; b < 64; b++) begin
      for (int w = 0; w < 4; w++) mem[b][32*w +: 32] = {8'(b), 8'(w), 16'hA5A5};
    end
    mem[4] = 128'h44444444_33333333_22222222_11111111;

    RESET_N = 1'b0; READ = 1'b0; WRITE = 1'b0; BYTE_EN = 4'h0; ADDRESS = '0; WRITEDATA = '0;
    repeat (2) @(posedge CLK);
    #2;
    check("rst_busywait", 128'(BUSYWAIT), 128'(0));
    check("rst_mem_read", 128'(MEM_READ), 128'(0));
    check("rst_mem_write", 128'(MEM_WRITE), 128'(0));
    check("rst_mem_addr", 128'(MEM_ADDRESS), 128'(0));
    check("rst_readdata", 128'(READDATA), 128'(0));
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    // Cold read miss into way 0.
    start(1, 0, 32'h40, 32'h0, 4'h0);
    check("t1_busy_now", 128'(BUSYWAIT), 128'(1));
    wait_ready();
    check("t1_fetch_addr", 128'(rd_addr), 128'(28'h4));
    check("t1_no_wb", 128'(saw_wr), 128'(0));
    check("t1_cycles", 128'(cyc), 128'(8));
    check("t1_data", 128'(READDATA), 128'(32'h11111111));
    finish_req();

    // Byte-lane store hit.
    start(0, 1, 32'h44, 32'hAABBCCDD, 4'b0010);
    check("t2_no_stall", 128'(BUSYWAIT), 128'(0));
    check("t2_no_mem", 128'({MEM_READ, MEM_WRITE}), 128'(0));
    finish_req();
    start(1, 0, 32'h44, 32'h0, 4'h0);
    check("t2_merged", 128'(READDATA), 128'(32'h2222CC22));
    finish_req();

    // Second tag at the same index fills way 1, then hits with no stall.
    start(1, 0, 32'hC0, 32'h0, 4'h0);
    wait_ready();
    check("t3_fetch_addr", 128'(rd_addr), 128'(28'hC));
    check("t3_cycles", 128'(cyc), 128'(8));
    check("t3_data", 128'(READDATA), 128'(32'h0C00A5A5));
    finish_req();
    start(1, 0, 32'hC0, 32'h0, 4'h0);
    check("t3_hit_no_stall", 128'(BUSYWAIT), 128'(0));
    check("t3_hit_data", 128'(READDATA), 128'(32'h0C00A5A5));
    finish_req();

    // Third tag evicts the dirty LRU line (way 0).
    start(1, 0, 32'h140, 32'h0, 4'h0);
    wait_ready();
    check("t4_wb_seen", 128'(saw_wr), 128'(1));
    check("t4_wb_addr", 128'(wr_addr), 128'(28'h4));
    check("t4_wb_data", wr_data, 128'h44444444_33333333_2222CC22_11111111);
    check("t4_fetch_addr", 128'(rd_addr), 128'(28'h14));
    check("t4_cycles", 128'(cyc), 128'(14));
    check("t4_data", 128'(READDATA), 128'(32'h1400A5A5));
    finish_req();
    start(1, 0, 32'hC0, 32'h0, 4'h0);
    check("t4_c0_still_hits", 128'(BUSYWAIT), 128'(0));
    finish_req();
    // 0x140 is now LRU and clean; refetching 0x44 returns the written-back merge.
    start(1, 0, 32'h44, 32'h0, 4'h0);
    wait_ready();
    check("t4_refetch_no_wb", 128'(saw_wr), 128'(0));
    check("t4_refetch_cycles", 128'(cyc), 128'(8));
    check("t4_refetch_data", 128'(READDATA), 128'(32'h2222CC22));
    finish_req();

    // Reset in the middle of a fetch.
    start(1, 0, 32'h1C0, 32'h0, 4'h0);
    repeat (3) begin @(posedge CLK); #2; end
    check("t5_in_fetch", 128'(MEM_READ), 128'(1));
    check("t5_fetch_addr", 128'(MEM_ADDRESS), 128'(28'h1C));
    RESET_N = 1'b0;
    #1;
    check("t5_rst_mem_read", 128'(MEM_READ), 128'(0));
    check("t5_rst_busywait", 128'(BUSYWAIT), 128'(0));
    check("t5_rst_mem_addr", 128'(MEM_ADDRESS), 128'(0));
    @(posedge CLK); #1;
    READ = 1'b0;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    start(1, 0, 32'hC0, 32'h0, 4'h0);
    check("t5_c0_miss", 128'(BUSYWAIT), 128'(1));
    wait_ready();
    check("t5_cycles", 128'(cyc), 128'(8));
    check("t5_data", 128'(READDATA), 128'(32'h0C00A5A5));
    finish_req();

    // READ and WRITE together act as a store.
    start(1, 1, 32'hC0, 32'hDEADBEEF, 4'hF);
    check("t6_no_stall", 128'(BUSYWAIT), 128'(0));
    @(posedge CLK); #1;
    WRITE = 1'b0;
    #1;
    check("t6_stored", 128'(READDATA), 128'(32'hDEADBEEF));
    finish_req();

    // Store with no byte lanes leaves the word untouched.
    start(0, 1, 32'hC4, 32'hFFFFFFFF, 4'h0);
    check("t7_no_stall", 128'(BUSYWAIT), 128'(0));
    @(posedge CLK); #1;
    WRITE = 1'b0; READ = 1'b1;
    #1;
    check("t7_unchanged", 128'(READDATA), 128'(32'h0C01A5A5));
    finish_req();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
